// File: rtl/write_ptr_full_if.sv
// -----------------------------------------------------------------------------
// write_ptr_full_if
// Bundles the write-side pointer signals of an asynchronous FIFO.
//   Winc         producer write request
//   RD_PTR_GRAY  Gray read pointer arriving from the read clock domain
//   write_addr   binary memory write address
//   W_EN         memory write strobe
//   WR_PTR_GRAY  Gray write pointer for the read-domain synchronizer
//   FULL_flag    full indication
//   WLEVEL       write-domain fill level
//   OVERFLOW     sticky write-while-full error
//   ALMOST_FULL  almost-full indication (only when WPTR_AFULL_EN is defined)
// Modports: master = producer / read-domain side, slave = write_ptr_full.
// The ADDR_W parameter must match the ADDR_W of the attached write_ptr_full.
// -----------------------------------------------------------------------------
interface write_ptr_full_if #(
  parameter int ADDR_W = 4
);
  logic              Winc;
  logic [ADDR_W:0]   RD_PTR_GRAY;
  logic [ADDR_W-1:0] write_addr;
  logic              W_EN;
  logic [ADDR_W:0]   WR_PTR_GRAY;
  logic              FULL_flag;
  logic [ADDR_W:0]   WLEVEL;
  logic              OVERFLOW;
`ifdef WPTR_AFULL_EN
  logic              ALMOST_FULL;

  modport master (
    output Winc, RD_PTR_GRAY,
    input  write_addr, W_EN, WR_PTR_GRAY, FULL_flag, WLEVEL, OVERFLOW, ALMOST_FULL
  );
  modport slave (
    input  Winc, RD_PTR_GRAY,
    output write_addr, W_EN, WR_PTR_GRAY, FULL_flag, WLEVEL, OVERFLOW, ALMOST_FULL
  );
`else
  modport master (
    output Winc, RD_PTR_GRAY,
    input  write_addr, W_EN, WR_PTR_GRAY, FULL_flag, WLEVEL, OVERFLOW
  );
  modport slave (
    input  Winc, RD_PTR_GRAY,
    output write_addr, W_EN, WR_PTR_GRAY, FULL_flag, WLEVEL, OVERFLOW
  );
`endif
endinterface

// File: rtl/write_ptr_full.sv
// -----------------------------------------------------------------------------
// write_ptr_full
// Write-domain pointer and full-flag logic of an asynchronous FIFO.
// Ports:
//   W_CLK  write-domain clock, all state on its rising edge
//   RST    synchronous active-high reset
//   bus    write_ptr_full_if.slave (Winc, RD_PTR_GRAY in; write_addr, W_EN,
//          WR_PTR_GRAY, FULL_flag, WLEVEL, OVERFLOW [, ALMOST_FULL] out)
// Parameters: ADDR_W (depth 2^ADDR_W), SYNC_STAGES (2..3), AFULL_TH.
// Optional feature: define WPTR_AFULL_EN to build the ALMOST_FULL output.
// -----------------------------------------------------------------------------
module write_ptr_full #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 2
) (
  input logic              W_CLK,
  input logic              RST,
  write_ptr_full_if.slave  bus
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  // Gray pattern of a pointer exactly DEPTH ahead: two MSBs inverted.
  localparam logic [PW-1:0] FULL_MASK_C = PW'(3) << (PW - 2);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wgray_r;
  logic [PW-1:0] level_r;
  logic          full_r;
  logic          ovf_r;
  logic [PW-1:0] rq_sync_r [SYNC_STAGES];

  logic          inc_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_sync_s;
  logic [PW-1:0] level_next_s;
  logic          full_next_s;

  assign inc_s = bus.Winc & ~full_r;

  // Next-state pointer, level and full computation.
  always_comb begin
    wbin_next_s = wbin_r;
    if (inc_s) begin
      wbin_next_s = wbin_r + PW'(1);
    end else begin
      wbin_next_s = wbin_r;
    end
    wgray_next_s = bin2gray(wbin_next_s);
    rbin_sync_s  = gray2bin(rq_sync_r[SYNC_STAGES-1]);
    level_next_s = wbin_next_s - rbin_sync_s;
    full_next_s  = (wgray_next_s == (rq_sync_r[SYNC_STAGES-1] ^ FULL_MASK_C));
  end

  // Read-pointer synchronizer chain; the only sampler of RD_PTR_GRAY.
  always_ff @(posedge W_CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_sync_r[i] <= {PW{1'b0}};
      end
    end else begin
      rq_sync_r[0] <= bus.RD_PTR_GRAY;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rq_sync_r[i] <= rq_sync_r[i-1];
      end
    end
  end

  // Write pointer, level, full and sticky overflow registers.
  always_ff @(posedge W_CLK) begin
    if (RST) begin
      wbin_r  <= {PW{1'b0}};
      wgray_r <= {PW{1'b0}};
      level_r <= {PW{1'b0}};
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      wbin_r  <= wbin_next_s;
      wgray_r <= wgray_next_s;
      level_r <= level_next_s;
      full_r  <= full_next_s;
      ovf_r   <= ovf_r | (bus.Winc & full_r);
    end
  end

`ifdef WPTR_AFULL_EN
  localparam logic [PW-1:0] AFULL_LVL_C = PW'(DEPTH - AFULL_TH);
  logic afull_r;

  // Almost-full register, timed like FULL_flag.
  always_ff @(posedge W_CLK) begin
    if (RST) begin
      afull_r <= 1'b0;
    end else begin
      afull_r <= (level_next_s >= AFULL_LVL_C);
    end
  end

  assign bus.ALMOST_FULL = afull_r;
`endif

  assign bus.write_addr  = wbin_r[ADDR_W-1:0];
  assign bus.WR_PTR_GRAY = wgray_r;
  assign bus.FULL_flag   = full_r;
  assign bus.WLEVEL      = level_r;
  assign bus.OVERFLOW    = ovf_r;
  // Strobe is combinational so the memory write lands on the same edge.
  assign bus.W_EN        = bus.Winc & ~full_r & ~RST;

endmodule

// File: tb/tb_write_ptr_full.sv
// -----------------------------------------------------------------------------
// tb_write_ptr_full
// Self-checking bench for write_ptr_full (ADDR_W=4, SYNC_STAGES=2, AFULL_TH=2).
// Directed vector table, hand sequences for wrap and mid-operation reset,
// then randomized traffic against a count-based reference model.
// -----------------------------------------------------------------------------
module tb_write_ptr_full;
  localparam int AW    = 4;
  localparam int PW    = 5;
  localparam int DEPTH = 16;

  logic W_CLK = 1'b0;
  logic RST;

  write_ptr_full_if #(.ADDR_W(AW)) bus ();

  write_ptr_full #(.ADDR_W(AW), .SYNC_STAGES(2), .AFULL_TH(2)) dut (
    .W_CLK (W_CLK),
    .RST   (RST),
    .bus   (bus.slave)
  );

  always #5 W_CLK = ~W_CLK;

  int tests = 0;
  int fails = 0;

  // Reference model: accepted write count and a two-deep delay line of read counts.
  int m_w, m_full, m_ovf, m_level;
  int hist[$];

  typedef struct {
    bit rst; bit winc; int rd;
    bit exp_wen; int exp_wbin; bit exp_full; int exp_level; bit exp_ovf;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_w = 0; m_full = 0; m_ovf = 0; m_level = 0;
    hist = {};
    hist.push_back(0);
    hist.push_back(0);
  endfunction

  function automatic void model_edge(input bit rst, input bit winc, input int rd);
    int synced;
    if (rst) begin
      model_reset();
    end else begin
      if (winc && m_full != 0) m_ovf = 1;
      if (winc && m_full == 0) m_w = (m_w + 1) % 32;
      synced  = hist.pop_front();
      m_level = (m_w - synced + 32) % 32;
      m_full  = (m_level == DEPTH) ? 1 : 0;
      hist.push_back(rd % 32);
    end
  endfunction

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_addr"},  bus.write_addr,  m_w % DEPTH);
    check({tag, "_gray"},  bus.WR_PTR_GRAY, gray(m_w));
    check({tag, "_full"},  bus.FULL_flag,   m_full);
    check({tag, "_level"}, bus.WLEVEL,      m_level);
    check({tag, "_ovf"},   bus.OVERFLOW,    m_ovf);
`ifdef WPTR_AFULL_EN
    check({tag, "_afull"}, bus.ALMOST_FULL, (m_level >= DEPTH - 2) ? 1 : 0);
`endif
  endtask

  task automatic drive(input bit rst, input bit winc, input int rd);
    logic [PW-1:0] r5;
    r5 = rd[PW-1:0];
    RST = rst;
    bus.Winc = winc;
    bus.RD_PTR_GRAY = r5 ^ (r5 >> 1);
  endtask

  // One model-checked cycle: W_EN before the edge, registered outputs after it.
  task automatic cycle(input string tag, input bit rst, input bit winc, input int rd);
    @(negedge W_CLK);
    drive(rst, winc, rd);
    #1;
    check({tag, "_wen"}, bus.W_EN, (winc && m_full == 0 && !rst) ? 1 : 0);
    @(posedge W_CLK);
    #1;
    model_edge(rst, winc, rd);
    check_model(tag);
  endtask

  task automatic add(input bit rst, input bit winc, input int rd, input bit wen,
                     input int wbin, input bit full, input int level, input bit ovf);
    vec_t v;
    v.rst = rst; v.winc = winc; v.rd = rd; v.exp_wen = wen; v.exp_wbin = wbin;
    v.exp_full = full; v.exp_level = level; v.exp_ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    int w_total, rd_total, wraps;
    logic [PW-1:0] prev_g;
    bit rst, winc;

    drive(1'b1, 1'b0, 0);
    model_reset();

    // Directed table: reset, fill, overflow, late full release, refill.
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(0, 1, 0, 1, k + 1, (k == 15), k + 1, 0);
    add(0, 1, 0, 0, 16, 1, 16, 1);
    add(0, 1, 0, 0, 16, 1, 16, 1);
    add(0, 0, 0, 0, 16, 1, 16, 1);
    add(0, 0, 1, 0, 16, 1, 16, 1);
    add(0, 0, 1, 0, 16, 1, 16, 1);
    add(0, 0, 1, 0, 16, 0, 15, 1);
    add(0, 1, 1, 1, 17, 1, 16, 1);
    add(0, 1, 1, 0, 17, 1, 16, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge W_CLK);
      drive(vecs[i].rst, vecs[i].winc, vecs[i].rd);
      #1;
      check("vec_wen", bus.W_EN, vecs[i].exp_wen);
      @(posedge W_CLK);
      #1;
      check("vec_addr",  bus.write_addr,  vecs[i].exp_wbin % DEPTH);
      check("vec_gray",  bus.WR_PTR_GRAY, gray(vecs[i].exp_wbin));
      check("vec_full",  bus.FULL_flag,   vecs[i].exp_full);
      check("vec_level", bus.WLEVEL,      vecs[i].exp_level);
      check("vec_ovf",   bus.OVERFLOW,    vecs[i].exp_ovf);
`ifdef WPTR_AFULL_EN
      check("vec_afull", bus.ALMOST_FULL, (vecs[i].exp_level >= 14) ? 1 : 0);
`endif
      model_edge(vecs[i].rst, vecs[i].winc, vecs[i].rd);
    end

    // Reset while partly full: everything clears and writes restart at 0.
    cycle("r38_rst", 1, 0, 0);
    for (int k = 0; k < 9; k++) cycle("r38_fill", 0, 1, 0);
    check("r38_level9", bus.WLEVEL, 9);
    cycle("r38_mid", 1, 1, 0);
    check("r38_addr0", bus.write_addr, 0);
    check("r38_gray0", bus.WR_PTR_GRAY, 0);
    check("r38_lvl0", bus.WLEVEL, 0);
    cycle("r38_resume", 0, 1, 0);
    check("r38_addr1", bus.write_addr, 1);

    // 40 writes with the reader trailing by 3: one Gray bit per step, one wrap.
    cycle("r37_rst", 1, 0, 0);
    w_total = 0; wraps = 0;
    prev_g = bus.WR_PTR_GRAY;
    for (int k = 0; k < 40; k++) begin
      cycle("r37", 0, 1, (w_total > 3) ? w_total - 3 : 0);
      w_total++;
      check("r37_onebit", $countones(prev_g ^ bus.WR_PTR_GRAY), 1);
      if (prev_g == 5'b10000 && bus.WR_PTR_GRAY == 5'b00000) wraps++;
      prev_g = bus.WR_PTR_GRAY;
    end
    check("r37_wrap_seen", wraps, 1);

    // Randomized traffic; the reader never passes the writer.
    cycle("rnd_rst", 1, 0, 0);
    w_total = 0; rd_total = 0;
    for (int k = 0; k < 800; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      winc = ($urandom_range(0, 99) < 60);
      if (!rst && rd_total < w_total && $urandom_range(0, 1) == 1) rd_total++;
      if (rst) begin
        w_total = 0; rd_total = 0;
      end else if (winc && m_full == 0) begin
        w_total++;
      end
      cycle("rnd", rst, winc, rd_total);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
